// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for the 256-bit RSA decryption core: loads N and d, then
// per block collects a ciphertext, runs the core and streams the plaintext back out.
module rsa_stream_ctrl #(
  parameter int OUT_BYTES = 31
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [7:0]   i_in_data,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [7:0]   o_out_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  input  logic         i_rekey,
  output logic         o_core_start,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_a,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished,
  output logic         o_busy,
  output logic [15:0]  o_block_cnt
);

  typedef enum logic [2:0] {
    S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND
  } state_t;

  localparam logic [5:0] LAST_IN  = 6'd31;
  localparam logic [5:0] LAST_OUT = 6'(OUT_BYTES - 1);

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [255:0]   n_q, n_d, d_q, d_d, a_q, a_d, out_q, out_d;
  logic [15:0]    blk_q, blk_d;
  logic           getting, rekey_hit, in_rdy, in_fire, out_fire;

  function automatic logic [255:0] shift_in(input logic [255:0] r, input logic [7:0] b);
    return {r[247:0], b};
  endfunction

  // Rekey is only honoured at a block boundary, and then the byte offered that cycle is refused.
  assign getting   = (state_q == S_GET_N) || (state_q == S_GET_D) || (state_q == S_GET_A);
  assign rekey_hit = (state_q == S_GET_A) && (cnt_q == 6'd0) && i_rekey;
  assign in_rdy    = getting && !rekey_hit;
  assign in_fire   = in_rdy && i_in_valid;
  assign out_fire  = (state_q == S_SEND) && i_out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    a_d     = a_q;
    out_d   = out_q;
    blk_d   = blk_q;
    case (state_q)
      S_GET_N: if (in_fire) begin
        n_d = shift_in(n_q, i_in_data);
        if (cnt_q == LAST_IN) begin state_d = S_GET_D; cnt_d = 6'd0; end
        else cnt_d = cnt_q + 6'd1;
      end
      S_GET_D: if (in_fire) begin
        d_d = shift_in(d_q, i_in_data);
        if (cnt_q == LAST_IN) begin state_d = S_GET_A; cnt_d = 6'd0; end
        else cnt_d = cnt_q + 6'd1;
      end
      S_GET_A: begin
        if (rekey_hit) begin
          state_d = S_GET_N;
          cnt_d   = 6'd0;
        end else if (in_fire) begin
          a_d = shift_in(a_q, i_in_data);
          if (cnt_q == LAST_IN) begin state_d = S_START; cnt_d = 6'd0; end
          else cnt_d = cnt_q + 6'd1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = 6'd0;
      end
      S_WAIT: if (i_core_finished) begin
        out_d   = i_core_result;
        state_d = S_SEND;
        cnt_d   = 6'd0;
      end
      S_SEND: if (out_fire) begin
        out_d = out_q << 8;
        if (cnt_q == LAST_OUT) begin
          state_d = S_GET_A;
          cnt_d   = 6'd0;
          blk_d   = blk_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_GET_N;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_GET_N;
      cnt_q   <= 6'd0;
      n_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      out_q   <= '0;
      blk_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      a_q     <= a_d;
      out_q   <= out_d;
      blk_q   <= blk_d;
    end
  end

  // Handshake flags are held low while reset is asserted, not just after the reset edge.
  assign o_in_ready   = i_rst_n && in_rdy;
  assign o_out_valid  = i_rst_n && (state_q == S_SEND);
  assign o_core_start = i_rst_n && (state_q == S_START);
  assign o_busy       = i_rst_n && ((state_q == S_START) || (state_q == S_WAIT) || (state_q == S_SEND));
  assign o_out_data   = out_q[8*OUT_BYTES-1 -: 8];
  assign o_core_n     = n_q;
  assign o_core_d     = d_q;
  assign o_core_a     = a_q;
  assign o_block_cnt  = blk_q;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Randomized bench for rsa_stream_ctrl: a queue-based transaction model is compared
// against the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_rsa_stream_ctrl;
  localparam int OB = 31;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [7:0]   i_in_data = 8'h00;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [7:0]   o_out_data;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic         i_rekey = 1'b0;
  logic         o_core_start;
  logic [255:0] o_core_n, o_core_d, o_core_a;
  logic [255:0] i_core_result;
  logic         i_core_finished;
  logic         o_busy;
  logic [15:0]  o_block_cnt;

  logic         fin_force = 1'b0;
  logic         core_fin_auto = 1'b0;
  logic [255:0] core_res = '0;
  assign i_core_finished = fin_force | core_fin_auto;
  assign i_core_result   = core_res;

  always #5 i_clk = ~i_clk;

  rsa_stream_ctrl #(.OUT_BYTES(OB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .i_rekey(i_rekey), .o_core_start(o_core_start),
    .o_core_n(o_core_n), .o_core_d(o_core_d), .o_core_a(o_core_a),
    .i_core_result(i_core_result), .i_core_finished(i_core_finished),
    .o_busy(o_busy), .o_block_cnt(o_block_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: bytes still owed for the key, ciphertext bytes so far,
  // and a queue of plaintext bytes the host has yet to take.
  bit           model_on = 0;
  int           key_left, ct;
  logic [255:0] mn, md, ma;
  bit           start_now, waiting;
  logic [7:0]   exp_q[$];
  logic [15:0]  mblk;

  initial forever begin
    @(posedge i_clk);
    if (!i_rst_n) begin
      model_on = 1; key_left = 64; ct = 0; mn = '0; md = '0; ma = '0;
      start_now = 0; waiting = 0; exp_q.delete(); mblk = 16'd0;
    end else if (model_on) begin
      if (start_now) begin
        start_now = 0; waiting = 1;
      end else if (waiting) begin
        if (i_core_finished) begin
          for (int k = OB - 1; k >= 0; k--) exp_q.push_back(i_core_result[8*k +: 8]);
          waiting = 0;
        end
      end else if (exp_q.size() > 0) begin
        if (i_out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) mblk = mblk + 16'd1;
        end
      end else if (key_left == 0 && ct == 0 && i_rekey) begin
        key_left = 64;
      end else if (i_in_valid) begin
        if (key_left > 32) begin mn = {mn[247:0], i_in_data}; key_left--; end
        else if (key_left > 0) begin md = {md[247:0], i_in_data}; key_left--; end
        else begin
          ma = {ma[247:0], i_in_data}; ct++;
          if (ct == 32) begin ct = 0; start_now = 1; end
        end
      end
    end
  end

  int           starts = 0;
  bit           core_start_seen = 0;
  logic [255:0] cap_n, cap_d, cap_a;

  initial forever begin
    bit loading;
    @(negedge i_clk);
    core_start_seen = (o_core_start === 1'b1);
    if (core_start_seen) begin
      starts++; cap_n = o_core_n; cap_d = o_core_d; cap_a = o_core_a;
    end
    if (model_on) begin
      loading = !start_now && !waiting && (exp_q.size() == 0);
      chk("in_ready", o_in_ready, i_rst_n && loading && !(key_left == 0 && ct == 0 && i_rekey));
      chk("out_valid", o_out_valid, i_rst_n && (exp_q.size() > 0));
      chk("core_start", o_core_start, i_rst_n && start_now);
      chk("busy", o_busy, i_rst_n && !loading);
      chk("block_cnt", o_block_cnt, mblk);
      chk("core_n", o_core_n, mn);
      chk("core_d", o_core_d, md);
      chk("core_a", o_core_a, ma);
      if (i_rst_n && exp_q.size() > 0) chk("out_data", o_out_data, exp_q[0]);
    end
  end

  // Core stand-in: raises finished fin_delay+1 cycles after each start pulse it sees.
  int fin_delay = 9;
  int core_timer = 0;
  initial forever begin
    @(posedge i_clk);
    #1;
    if (core_timer > 0) begin
      core_timer--;
      core_fin_auto = (core_timer == 0);
    end else begin
      core_fin_auto = 1'b0;
    end
    if (core_start_seen) core_timer = fin_delay;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic put(input logic [7:0] b, input bit gaps);
    int  g = 0;
    bit  acc = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      i_in_valid = 1'b0; i_in_data = 8'($urandom); tick();
    end
    i_in_valid = 1'b1; i_in_data = b;
    do begin
      @(negedge i_clk);
      acc = o_in_ready;
      tick();
      g++;
    end while (!acc && g < 400);
    i_in_valid = 1'b0;
    chk("put_accept", acc, 1);
  endtask

  task automatic load256(input logic [255:0] v, input bit gaps, input bit rekey5, input bit fin_in_start);
    for (int i = 31; i >= 0; i--) begin
      if (rekey5 && i == 26) i_rekey = 1'b1;
      put(v[8*i +: 8], gaps);
      if (rekey5 && i == 26) i_rekey = 1'b0;
    end
    if (fin_in_start) begin
      fin_force = 1'b1;
      @(negedge i_clk);
      chk("start_cycle", o_core_start, 1);
      tick();
      fin_force = 1'b0;
    end
  endtask

  logic [7:0] got[$];

  task automatic drain(input int mode, input int abort_at);
    int         cyc = 0;
    bit         stall = 0;
    logic [7:0] held = 8'h00;
    got.delete();
    while (got.size() < OB && cyc < 600) begin
      case (mode)
        0:       i_out_ready = 1'b1;
        1:       i_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge i_clk);
      if (stall && o_out_valid) chk("held_byte", o_out_data, held);
      stall = o_out_valid && !i_out_ready;
      held  = o_out_data;
      if (mode == 1 && o_out_valid) chk("in_ready_bp", o_in_ready, 0);
      if (o_out_valid && i_out_ready) got.push_back(o_out_data);
      tick();
      cyc++;
      if (abort_at > 0 && got.size() == abort_at) begin
        i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
        break;
      end
    end
    i_out_ready = 1'b0;
    if (abort_at == 0) chk("drain_count", got.size(), OB);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] new_n, r;
    int s0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("lit_reset_in_ready", o_in_ready, 1);
    chk("lit_reset_blk", o_block_cnt, 0);
    chk("lit_reset_busy", o_busy, 0);
    tick();

    // Key load and single block with a known result.
    for (int i = 0; i < 32; i++) r[8*(31-i) +: 8] = 8'(i + 1);
    core_res = r; fin_delay = 9;
    load256(256'hCA1, 0, 0, 0);
    load256(256'h2B, 0, 0, 0);
    load256(256'h5, 0, 0, 0);
    drain(0, 0);
    for (int k = 0; k < OB && k < got.size(); k++) chk("lit_plain_byte", got[k], 8'(k + 2));
    chk("lit_starts1", starts, 1);
    chk("lit_cap_n", cap_n, 256'hCA1);
    chk("lit_cap_d", cap_d, 256'h2B);
    chk("lit_cap_a", cap_a, 256'h5);
    chk("lit_blk1", o_block_cnt, 1);

    // Three blocks back to back, random gaps and random host backpressure.
    s0 = starts;
    for (int b = 1; b <= 3; b++) begin
      core_res = rand256();
      load256(256'(b), 1, 0, 0);
      drain(2, 0);
      chk("lit_cap_n_kept", cap_n, 256'hCA1);
      chk("lit_cap_d_kept", cap_d, 256'h2B);
      chk("lit_cap_a_blk", cap_a, 256'(b));
    end
    chk("lit_starts3", starts - s0, 3);
    chk("lit_blk4", o_block_cnt, 4);

    // Backpressure pattern 1,0,0,1 and an ignored rekey at ciphertext byte 5.
    core_res = rand256();
    load256(rand256(), 0, 1, 0);
    drain(1, 0);
    chk("lit_cap_n_after_rekey5", cap_n, 256'hCA1);

    // Spurious finished at idle and in the start cycle; the real one arrives later.
    fin_force = 1'b1; tick(); fin_force = 1'b0;
    @(negedge i_clk);
    chk("lit_spurious_valid", o_out_valid, 0);
    chk("lit_spurious_ready", o_in_ready, 1);
    fin_delay = 4; core_res = rand256();
    load256(rand256(), 1, 0, 1);
    drain(0, 0);

    // Rekey at an idle block boundary refuses the offered byte and reloads N.
    i_rekey = 1'b1; i_in_valid = 1'b1; i_in_data = 8'hAA;
    @(negedge i_clk);
    chk("lit_rekey_refused", o_in_ready, 0);
    tick();
    i_rekey = 1'b0; i_in_valid = 1'b0;
    new_n = rand256();
    load256(new_n, 1, 0, 0);
    load256(256'h2B, 0, 0, 0);
    core_res = rand256();
    load256(rand256(), 0, 0, 0);
    drain(2, 0);
    chk("lit_new_n", cap_n, new_n);

    // Reset while waiting on the core; its late finished must be ignored.
    fin_delay = 9;
    load256(rand256(), 0, 0, 0);
    repeat (3) tick();
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("lit_rst_wait_blk", o_block_cnt, 0);
    chk("lit_rst_wait_busy", o_busy, 0);
    chk("lit_rst_wait_n", o_core_n, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      @(negedge i_clk);
      chk("lit_late_fin_valid", o_out_valid, 0);
    end
    tick();

    // Reload everything, then reset after the tenth output byte.
    load256(256'hCA1, 1, 0, 0);
    load256(256'h2B, 1, 0, 0);
    core_res = rand256();
    load256(rand256(), 1, 0, 0);
    drain(0, 10);
    @(negedge i_clk);
    chk("lit_rst_send_valid", o_out_valid, 0);
    chk("lit_rst_send_blk", o_block_cnt, 0);
    chk("lit_rst_send_ready", o_in_ready, 1);
    tick();
    load256(256'hCA1, 0, 0, 0);
    load256(256'h2B, 0, 0, 0);
    core_res = rand256();
    load256(rand256(), 0, 0, 0);
    drain(2, 0);
    chk("lit_final_blk", o_block_cnt, 1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
